// File: rtl/md_issue_ctrl.sv
// EX-stage issue controller for the HI/LO multiply/divide unit.
// Sends a one-cycle start pulse, tracks the unit's busy window, stalls
// only MD-dependent instructions, returns HI/LO read data, and provides
// a hang watchdog plus issue/stall performance counters.
module md_issue_ctrl #(
  parameter int         TIMEOUT   = 64,
  parameter int         CNT_W     = 32,
  // The mthi/mtlo ctrl codes from the shared constants file.
  parameter logic [3:0] MT_SET_HI = 4'd8,
  parameter logic [3:0] MT_SET_LO = 4'd9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_md_op,
  input  logic [3:0]       ex_md_ctrl,
  input  logic             ex_md_read,
  input  logic             ex_read_hi,
  input  logic [31:0]      ex_rs,
  input  logic [31:0]      ex_rt,
  input  logic             ex_flush,
  output logic             md_start,
  output logic [3:0]       md_ctrl,
  output logic [31:0]      md_A,
  output logic [31:0]      md_B,
  input  logic             md_busy,
  input  logic [31:0]      md_HI,
  input  logic [31:0]      md_LO,
  output logic             stall,
  output logic [31:0]      rd_data,
  output logic             err_timeout,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] stall_count
);

  localparam int              WC_W      = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX    = '1;
  localparam logic [WC_W-1:0] WC_LIMIT  = WC_W'(TIMEOUT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [WC_W-1:0] r_wait_cnt;
  logic [WC_W-1:0] w_wait_cnt_nxt;
  logic [WC_W-1:0] w_wait_cnt_inc;
  logic            r_err;
  logic            w_err_set;
  logic [CNT_W-1:0] r_op_count;
  logic [CNT_W-1:0] r_stall_count;

  logic w_need;
  logic w_is_set;
  logic w_stall;
  logic w_start;

  // Decode, stall and start; reset gates both so nothing leaks out while held.
  assign w_need   = ex_valid & ~ex_flush & (ex_md_op | ex_md_read);
  assign w_is_set = (ex_md_ctrl == MT_SET_HI) | (ex_md_ctrl == MT_SET_LO);
  // Stalling on md_busy as well as WAIT also keeps start off while the unit
  // is busy, so the unit is never restarted from here.
  assign w_stall  = ~reset & w_need & ((r_state == S_WAIT) | md_busy);
  assign w_start  = ~reset & ex_valid & ex_md_op & ~ex_flush & ~w_stall;

  assign md_start    = w_start;
  assign md_ctrl     = ex_md_ctrl;
  assign md_A        = ex_rs;
  assign md_B        = ex_rt;
  assign stall       = w_stall;
  assign rd_data     = ex_read_hi ? md_HI : md_LO;
  assign err_timeout = r_err;
  assign op_count    = r_op_count;
  assign stall_count = r_stall_count;

  // Saturating increment of the WAIT-cycle counter.
  assign w_wait_cnt_inc = (r_wait_cnt == WC_MAX) ? r_wait_cnt : r_wait_cnt + 1'b1;

  // Next-state logic: IDLE launches long ops into WAIT; WAIT leaves on busy fall or watchdog.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_err_set      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // mthi/mtlo complete at the start edge, so they never enter WAIT.
        if (w_start && !w_is_set) begin
          w_state_nxt    = S_WAIT;
          w_wait_cnt_nxt = '0;
        end
      end
      S_WAIT: begin
        w_wait_cnt_nxt = w_wait_cnt_inc;
        if (!md_busy) begin
          w_state_nxt = S_IDLE;
        end else if (w_wait_cnt_inc == WC_LIMIT) begin
          // Unit appears hung: flag it and release the pipeline.
          w_err_set   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state, watchdog counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  // Performance counters; both wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_count    <= '0;
      r_stall_count <= '0;
    end else begin
      r_op_count    <= r_op_count + CNT_W'(w_start);
      r_stall_count <= r_stall_count + CNT_W'(w_stall);
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed testbench for md_issue_ctrl with a small behavioural MD unit.
module tb_md_issue_ctrl;

  localparam int         TIMEOUT   = 64;
  localparam int         CNT_W     = 32;
  localparam logic [3:0] MT_MULT   = 4'd0;
  localparam logic [3:0] MT_MULTU  = 4'd1;
  localparam logic [3:0] MT_DIV    = 4'd2;
  localparam logic [3:0] MT_SET_HI = 4'd8;
  localparam logic [3:0] MT_SET_LO = 4'd9;

  logic             clk = 1'b0;
  logic             reset;
  logic             ex_valid, ex_md_op, ex_md_read, ex_read_hi, ex_flush;
  logic [3:0]       ex_md_ctrl;
  logic [31:0]      ex_rs, ex_rt;
  logic             md_start, stall, err_timeout;
  logic [3:0]       md_ctrl;
  logic [31:0]      md_A, md_B, md_HI, md_LO, rd_data;
  logic             md_busy;
  logic [CNT_W-1:0] op_count, stall_count;

  int total = 0;
  int bad   = 0;

  // Behavioural MD unit: 3 busy cycles, HI/LO written at the edge busy falls.
  logic        m_busy     = 1'b0;
  logic [1:0]  m_cnt      = 2'd0;
  logic [31:0] m_hi       = 32'h0;
  logic [31:0] m_lo       = 32'h0;
  logic [31:0] p_hi       = 32'h0;
  logic [31:0] p_lo       = 32'h0;
  logic        force_busy = 1'b0;

  assign md_busy = m_busy | force_busy;
  assign md_HI   = m_hi;
  assign md_LO   = m_lo;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    logic signed [63:0] sa, sb;
    logic        [63:0] prod;
    sa = {{32{md_A[31]}}, md_A};
    sb = {{32{md_B[31]}}, md_B};
    if (md_start) begin
      if (md_ctrl == MT_SET_HI) m_hi <= md_A;
      else if (md_ctrl == MT_SET_LO) m_lo <= md_A;
      else begin
        m_busy <= 1'b1;
        m_cnt  <= 2'd3;
        p_hi   <= m_hi;
        p_lo   <= m_lo;
        if (md_ctrl == MT_MULT) begin
          prod = sa * sb;
          p_hi <= prod[63:32];
          p_lo <= prod[31:0];
        end else if (md_ctrl == MT_MULTU) begin
          prod = {32'h0, md_A} * {32'h0, md_B};
          p_hi <= prod[63:32];
          p_lo <= prod[31:0];
        end else if (md_ctrl == MT_DIV && md_B != 32'h0) begin
          p_lo <= $signed(md_A) / $signed(md_B);
          p_hi <= $signed(md_A) % $signed(md_B);
        end
      end
    end else if (m_busy) begin
      if (m_cnt == 2'd1) begin
        m_busy <= 1'b0;
        m_hi   <= p_hi;
        m_lo   <= p_lo;
      end else begin
        m_cnt <= m_cnt - 2'd1;
      end
    end
  end

  md_issue_ctrl #(
    .TIMEOUT  (TIMEOUT),
    .CNT_W    (CNT_W),
    .MT_SET_HI(MT_SET_HI),
    .MT_SET_LO(MT_SET_LO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ex_valid   (ex_valid),
    .ex_md_op   (ex_md_op),
    .ex_md_ctrl (ex_md_ctrl),
    .ex_md_read (ex_md_read),
    .ex_read_hi (ex_read_hi),
    .ex_rs      (ex_rs),
    .ex_rt      (ex_rt),
    .ex_flush   (ex_flush),
    .md_start   (md_start),
    .md_ctrl    (md_ctrl),
    .md_A       (md_A),
    .md_B       (md_B),
    .md_busy    (md_busy),
    .md_HI      (md_HI),
    .md_LO      (md_LO),
    .stall      (stall),
    .rd_data    (rd_data),
    .err_timeout(err_timeout),
    .op_count   (op_count),
    .stall_count(stall_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    ex_valid   = 1'b0;
    ex_md_op   = 1'b0;
    ex_md_read = 1'b0;
    ex_read_hi = 1'b0;
    ex_flush   = 1'b0;
    ex_md_ctrl = 4'd0;
    ex_rs      = 32'h0;
    ex_rt      = 32'h0;
  endtask

  task automatic set_op(input logic [3:0] ctrl, input logic [31:0] rs, input logic [31:0] rt);
    set_idle();
    ex_valid   = 1'b1;
    ex_md_op   = 1'b1;
    ex_md_ctrl = ctrl;
    ex_rs      = rs;
    ex_rt      = rt;
  endtask

  task automatic set_read(input logic hi);
    set_idle();
    ex_valid   = 1'b1;
    ex_md_read = 1'b1;
    ex_read_hi = hi;
  endtask

  // Holds the current read in EX until stall drops; returns stalled cycles.
  task automatic wait_unstall(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_op(MT_MULT, 32'd1, 32'd1);
    force_busy = 1'b1;
    @(negedge clk);
    total++; if (md_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", md_start); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    step();
    force_busy = 1'b0;
    reset = 1'b0;
    set_idle();
    @(negedge clk);
    total++; if (op_count !== 32'd0) begin bad++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
    total++; if (stall_count !== 32'd0) begin bad++; $display("FAIL reset_stall_count got=%0d exp=0", stall_count); end
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_timeout); end
    step();
  endtask

  task automatic test_mult_mflo();
    int n;
    set_op(MT_MULT, 32'd3, 32'd5);
    @(negedge clk);
    total++; if (md_start !== 1'b1) begin bad++; $display("FAIL mult_start got=%b exp=1", md_start); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL mult_issue_stall got=%b exp=0", stall); end
    total++; if ({md_ctrl, md_A, md_B} !== {MT_MULT, 32'd3, 32'd5}) begin bad++; $display("FAIL mult_passthru got=%h/%h/%h exp=0/3/5", md_ctrl, md_A, md_B); end
    step();
    set_read(1'b0);
    wait_unstall(n);
    total++; if (n !== 4) begin bad++; $display("FAIL mflo_stall_cycles got=%0d exp=4", n); end
    total++; if (rd_data !== 32'd15) begin bad++; $display("FAIL mflo_data got=%0d exp=15", rd_data); end
    total++; if (op_count !== 32'd1) begin bad++; $display("FAIL mult_op_count got=%0d exp=1", op_count); end
    total++; if (stall_count !== 32'd4) begin bad++; $display("FAIL mult_stall_count got=%0d exp=4", stall_count); end
    step();
    set_idle();
  endtask

  task automatic test_div_zero();
    int n;
    set_op(MT_DIV, 32'd7, 32'd0);
    @(negedge clk);
    total++; if (md_start !== 1'b1) begin bad++; $display("FAIL div_start got=%b exp=1", md_start); end
    step();
    set_read(1'b1);
    wait_unstall(n);
    total++; if (n !== 4) begin bad++; $display("FAIL div_stall_cycles got=%0d exp=4", n); end
    total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL div_hi got=%h exp=0", rd_data); end
    ex_read_hi = 1'b0;
    #1;
    total++; if (rd_data !== 32'd15) begin bad++; $display("FAIL div_lo got=%h exp=f", rd_data); end
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL div_err got=%b exp=0", err_timeout); end
    total++; if (op_count !== 32'd2) begin bad++; $display("FAIL div_op_count got=%0d exp=2", op_count); end
    step();
    set_idle();
  endtask

  task automatic test_mthi_mfhi();
    set_op(MT_SET_HI, 32'hDEADBEEF, 32'h0);
    @(negedge clk);
    total++; if (md_start !== 1'b1) begin bad++; $display("FAIL mthi_start got=%b exp=1", md_start); end
    step();
    set_read(1'b1);
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL mfhi_after_mthi_stall got=%b exp=0", stall); end
    total++; if (rd_data !== 32'hDEADBEEF) begin bad++; $display("FAIL mfhi_after_mthi_data got=%h exp=deadbeef", rd_data); end
    step();
    // Another MD op right away must issue: the FSM stayed in IDLE.
    set_op(MT_SET_LO, 32'h0000_0015, 32'h0);
    @(negedge clk);
    total++; if (md_start !== 1'b1) begin bad++; $display("FAIL mtlo_after_mthi_start got=%b exp=1", md_start); end
    total++; if (stall_count !== 32'd8) begin bad++; $display("FAIL mthi_stall_count got=%0d exp=8", stall_count); end
    step();
    set_idle();
  endtask

  task automatic test_alu_overlap();
    set_op(MT_MULTU, 32'hFFFFFFFF, 32'd2);
    @(negedge clk);
    total++; if (md_start !== 1'b1) begin bad++; $display("FAIL multu_start got=%b exp=1", md_start); end
    step();
    for (int i = 0; i < 5; i++) begin
      set_idle();
      ex_valid = 1'b1;
      @(negedge clk);
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall_%0d got=%b exp=0", i, stall); end
      step();
    end
    set_read(1'b0);
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL multu_mflo_stall got=%b exp=0", stall); end
    total++; if (rd_data !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_lo got=%h exp=fffffffe", rd_data); end
    ex_read_hi = 1'b1;
    #1;
    total++; if (rd_data !== 32'h1) begin bad++; $display("FAIL multu_hi got=%h exp=1", rd_data); end
    total++; if (op_count !== 32'd5) begin bad++; $display("FAIL multu_op_count got=%0d exp=5", op_count); end
    step();
    set_idle();
  endtask

  task automatic test_flush();
    int n;
    set_op(MT_MULT, 32'd2, 32'd2);
    ex_flush = 1'b1;
    @(negedge clk);
    total++; if (md_start !== 1'b0) begin bad++; $display("FAIL flush_start got=%b exp=0", md_start); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", stall); end
    step();
    set_idle();
    @(negedge clk);
    total++; if (op_count !== 32'd5) begin bad++; $display("FAIL flush_op_count got=%0d exp=5", op_count); end
    total++; if (stall_count !== 32'd8) begin bad++; $display("FAIL flush_stall_count got=%0d exp=8", stall_count); end
    step();
    // A flushed dependent read during WAIT does not stall; the op completes.
    set_op(MT_MULT, 32'd2, 32'd2);
    step();
    set_read(1'b0);
    ex_flush = 1'b1;
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_wait_stall got=%b exp=0", stall); end
    step();
    set_read(1'b0);
    wait_unstall(n);
    total++; if (n !== 3) begin bad++; $display("FAIL flush_wait_cycles got=%0d exp=3", n); end
    total++; if (rd_data !== 32'd4) begin bad++; $display("FAIL flush_wait_data got=%0d exp=4", rd_data); end
    step();
    set_idle();
  endtask

  task automatic test_reset_mid_wait();
    set_op(MT_MULT, 32'd6, 32'd7);
    step();
    reset = 1'b1;
    set_read(1'b0);
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_mid_wait_stall got=%b exp=0", stall); end
    step();
    reset = 1'b0;
    set_idle();
    for (int i = 0; i < 10 && md_busy; i++) step();
    @(negedge clk);
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL reset_mid_wait_drain got=%b exp=0", md_busy); end
    total++; if (op_count !== 32'd0) begin bad++; $display("FAIL reset_mid_wait_op_count got=%0d exp=0", op_count); end
    set_read(1'b0);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_mid_wait_idle got=%b exp=0", stall); end
    total++; if (rd_data !== 32'd42) begin bad++; $display("FAIL reset_mid_wait_data got=%0d exp=42", rd_data); end
    step();
    set_idle();
  endtask

  task automatic test_timeout();
    set_op(MT_MULT, 32'd1, 32'd1);
    @(negedge clk);
    total++; if (md_start !== 1'b1) begin bad++; $display("FAIL to_start got=%b exp=1", md_start); end
    step();
    for (int k = 1; k <= TIMEOUT + 2; k++) begin
      set_read(1'b0);
      force_busy = 1'b1;
      @(negedge clk);
      if (k == TIMEOUT) begin
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL to_early got=%b exp=0", err_timeout); end
      end
      if (k == TIMEOUT + 1) begin
        total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_set got=%b exp=1", err_timeout); end
      end
      step();
    end
    force_busy = 1'b0;
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL to_release got=%b exp=0", stall); end
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", err_timeout); end
    total++; if (stall_count !== 32'(TIMEOUT + 2)) begin bad++; $display("FAIL to_stall_count got=%0d exp=%0d", stall_count, TIMEOUT + 2); end
    total++; if (op_count !== 32'd1) begin bad++; $display("FAIL to_op_count got=%0d exp=1", op_count); end
    step();
    reset = 1'b1;
    set_idle();
    step();
    reset = 1'b0;
    @(negedge clk);
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL to_reset_err got=%b exp=0", err_timeout); end
    total++; if (op_count !== 32'd0) begin bad++; $display("FAIL to_reset_op got=%0d exp=0", op_count); end
    total++; if (stall_count !== 32'd0) begin bad++; $display("FAIL to_reset_stall got=%0d exp=0", stall_count); end
    step();
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    test_reset();
    test_mult_mflo();
    test_div_zero();
    test_mthi_mfhi();
    test_alu_overlap();
    test_flush();
    test_reset_mid_wait();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
